// File: rtl/alu_rs_sched_pkg.sv
// Shared types for the ALU reservation station: micro-op payload, RS entry and
// the ROB flush-range helper that other functional units reuse.
package alu_rs_sched_pkg;

    localparam int RS_DEPTH      = 8;
    localparam int RS_N_CDB      = 2;
    localparam int ROB_DEPTH_DEF = 16;

    typedef struct packed {
        logic [6:0]  pd;
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic        ps1_ready;
        logic        ps2_ready;
        logic [4:0]  rob_index;
        logic [6:0]  Opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
    } rs_data;

    typedef struct packed {
        logic   valid;
        rs_data data;
    } rs_entry_t;

    // True when tag lies strictly between mis_tag and tail, walking the ROB ring.
    function automatic logic rob_in_flush_range(input logic [4:0] tag,
                                                input logic [4:0] mis_tag,
                                                input logic [4:0] tail,
                                                input int         rob_depth = ROB_DEPTH_DEF);
        int dist_tag;
        int dist_tail;
        dist_tag  = ((int'(tag)  % rob_depth) - (int'(mis_tag) % rob_depth) + rob_depth) % rob_depth;
        dist_tail = ((int'(tail) % rob_depth) - (int'(mis_tag) % rob_depth) + rob_depth) % rob_depth;
        return (dist_tag != 0) && (dist_tag < dist_tail);
    endfunction

endpackage

// File: rtl/alu_rs_sched_age_select.sv
// Oldest-ready picker: grants the requesting entry that no other requester is older than.
module rs_age_select
    import alu_rs_sched_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        valid
);

    logic [DEPTH-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && req[j] && age[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign grant = req & ~blocked;
    assign valid = |req;

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station and issue scheduler with CDB wakeup and mispredict flush.
// Optional ALU_RS_BYPASS_EN: same-cycle CDB matches count as ready for select and dispatch.
module alu_rs_sched
    import alu_rs_sched_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int N_CDB     = RS_N_CDB,
    parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dispatch_valid,
    input  rs_data                    dispatch_data,
    output logic                      dispatch_ready,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB-1:0][6:0]     cdb_tag,
    input  logic                      fu_ready,
    input  logic [4:0]                curr_rob_tag,
    input  logic                      mispredict,
    input  logic [4:0]                mispredict_tag,
    output logic                      issued,
    output rs_data                    issue_data,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    rs_entry_t [DEPTH-1:0]           entries;
    logic [DEPTH-1:0][DEPTH-1:0]     age;
    logic [OCC_W-1:0]                occ;
    logic                            issued_q;
    rs_data                          issue_q;

    logic [DEPTH-1:0]                req;
    logic [DEPTH-1:0]                grant;
    logic [DEPTH-1:0]                kill;
    logic [DEPTH-1:0]                next_valid;
    logic                            grant_valid;
    logic [IDX_W-1:0]                grant_idx;
    logic [IDX_W-1:0]                free_idx;
    logic                            free_found;
    logic                            dispatch_fire;
    logic [OCC_W-1:0]                next_occ;
    rs_data                          dispatch_wr;

    function automatic logic cdb_hit(input logic [6:0]            tag,
                                     input logic [N_CDB-1:0]      vld,
                                     input logic [N_CDB-1:0][6:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N_CDB; c++) begin
            if (vld[c] && tags[c] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        req  = '0;
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic rdy1;
            logic rdy2;
            rdy1 = entries[i].data.ps1_ready || (entries[i].data.ps1 == '0);
            rdy2 = entries[i].data.ps2_ready || (entries[i].data.ps2 == '0);
`ifdef ALU_RS_BYPASS_EN
            rdy1 = rdy1 || cdb_hit(entries[i].data.ps1, cdb_valid, cdb_tag);
            rdy2 = rdy2 || cdb_hit(entries[i].data.ps2, cdb_valid, cdb_tag);
`endif
            req[i]  = entries[i].valid && rdy1 && rdy2 && !mispredict && fu_ready;
            kill[i] = mispredict && rob_in_flush_range(entries[i].data.rob_index,
                                                       mispredict_tag, curr_rob_tag, ROB_DEPTH);
        end
    end

    rs_age_select #(.DEPTH(DEPTH)) u_select (
        .req   (req),
        .age   (age),
        .grant (grant),
        .valid (grant_valid)
    );

    // Free slot search uses the registered valid bits, so a slot issued this cycle stays busy.
    always_comb begin
        grant_idx  = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
            if (!entries[i].valid && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign dispatch_ready = (occ != OCC_W'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready && free_found &&
                            !(mispredict && rob_in_flush_range(dispatch_data.rob_index,
                                                               mispredict_tag, curr_rob_tag, ROB_DEPTH));

    always_comb begin
        dispatch_wr = dispatch_data;
`ifdef ALU_RS_BYPASS_EN
        dispatch_wr.ps1_ready = dispatch_data.ps1_ready || cdb_hit(dispatch_data.ps1, cdb_valid, cdb_tag);
        dispatch_wr.ps2_ready = dispatch_data.ps2_ready || cdb_hit(dispatch_data.ps2, cdb_valid, cdb_tag);
`endif
    end

    always_comb begin
        next_valid = '0;
        next_occ   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_valid[i] = entries[i].valid && !kill[i] && !grant[i];
            if (dispatch_fire && free_idx == IDX_W'(i)) begin
                next_valid[i] = 1'b1;
            end
            next_occ = next_occ + OCC_W'(next_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entries  <= '0;
            age      <= '0;
            occ      <= '0;
            issued_q <= 1'b0;
            issue_q  <= '0;
        end else begin
            occ      <= next_occ;
            issued_q <= grant_valid;
            if (grant_valid) begin
                issue_q           <= entries[grant_idx].data;
                issue_q.ps1_ready <= 1'b1;
                issue_q.ps2_ready <= 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= next_valid[i];
                if (cdb_hit(entries[i].data.ps1, cdb_valid, cdb_tag)) begin
                    entries[i].data.ps1_ready <= 1'b1;
                end
                if (cdb_hit(entries[i].data.ps2, cdb_valid, cdb_tag)) begin
                    entries[i].data.ps2_ready <= 1'b1;
                end
            end
            // New entry is younger than everything currently held.
            if (dispatch_fire) begin
                entries[free_idx].data <= dispatch_wr;
                age[free_idx]          <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (entries[j].valid) begin
                        age[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    assign issued     = issued_q &&
                        !(mispredict && rob_in_flush_range(issue_q.rob_index, mispredict_tag,
                                                           curr_rob_tag, ROB_DEPTH));
    assign issue_data = issue_q;
    assign occupancy  = occ;

endmodule
